// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clk_div_bank divider bank.
package clk_div_pkg;

    localparam int unsigned MAX_CH      = 16;
    localparam int unsigned DEFAULT_DIV = 4;

    // Channel-select width; a single-channel bank still gets a 1-bit select.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadow/active ratio, phase counter, boundary commit.
// CLK_DIV_BANK_ODD_HALF_EN adds a negedge stage for exact 50% duty on odd ratios.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DEF_DIV = DEFAULT_DIV
) (
    input  logic             clk_100m,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             sync,
    output logic             clk_out,
    output logic             ce_out,
    output logic [DIV_W-1:0] active_div
);

    localparam logic [DIV_W-1:0] DefRatio = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] shd_q, shd_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] ph_q, ph_d;
    logic             run_q, run_d;
    logic             clk_q, clk_d;
    logic             ce_q, ce_d;
    logic             wrap, commit;

    always_comb begin
        shd_d  = wr_en ? wr_div : shd_q;
        wrap   = run_q && (ph_q == act_q - DIV_W'(1));
        // An idle channel (after reset or stopped) re-commits every cycle.
        commit = sync || !run_q || wrap;
        act_d  = act_q;
        if (commit) begin
            act_d = (sync && wr_en) ? wr_div : shd_q;
        end
        run_d = (act_d >= DIV_W'(2));
        ph_d  = (commit || !run_d) ? '0 : ph_q + DIV_W'(1);
        clk_d = run_d && (ph_d < (act_d >> 1));
        ce_d  = run_d && (ph_d == '0);
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            shd_q <= DefRatio;
            act_q <= DefRatio;
            ph_q  <= '0;
            run_q <= 1'b0;
            clk_q <= 1'b0;
            ce_q  <= 1'b0;
        end else begin
            shd_q <= shd_d;
            act_q <= act_d;
            ph_q  <= ph_d;
            run_q <= run_d;
            clk_q <= clk_d;
            ce_q  <= ce_d;
        end
    end

`ifdef CLK_DIV_BANK_ODD_HALF_EN
    logic neg_q;

    // Holds the high level half a cycle past the last high posedge for odd ratios.
    always_ff @(negedge clk_100m or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= clk_q && act_q[0];
        end
    end

    assign clk_out = clk_q | neg_q;
`else
    assign clk_out = clk_q;
`endif

    assign ce_out     = ce_q;
    assign active_div = act_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH runtime-programmable clock dividers with a shared phase-sync pulse.
// Optional macro CLK_DIV_BANK_ODD_HALF_EN: exact 50% duty for odd ratios.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DEF_DIV = DEFAULT_DIV
) (
    input  logic                      clk_100m,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]          cfg_div,
    input  logic                      sync_all,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         ce_out,
    output logic [NUM_CH*DIV_W-1:0]   active_div
);

    localparam int unsigned CH_W = ch_w(NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_en;

        // Selects at or above NUM_CH match no channel and are dropped.
        assign wr_en = cfg_we && (cfg_ch == CH_W'(i));

        clk_div_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_100m   (clk_100m),
            .rst        (rst),
            .wr_en      (wr_en),
            .wr_div     (cfg_div),
            .sync       (sync_all),
            .clk_out    (clk_out[i]),
            .ce_out     (ce_out[i]),
            .active_div (active_div[i*DIV_W +: DIV_W])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized self-checking bench for clk_div_bank against a period-level reference model.
module tb_clk_div_bank;

    localparam int NUM_CH  = 6;
    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 4;
    localparam int CH_W    = 3;

    logic                    clk_100m = 1'b0;
    logic                    rst = 1'b1;
    logic                    cfg_we = 1'b0;
    logic [CH_W-1:0]         cfg_ch = '0;
    logic [DIV_W-1:0]        cfg_div = '0;
    logic                    sync_all = 1'b0;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       ce_out;
    logic [NUM_CH*DIV_W-1:0] active_div;

    int errors = 0;
    int checks = 0;

    // Reference model: each channel's current period began at cycle m_start with ratio m_a.
    int m_a[NUM_CH];
    int m_s[NUM_CH];
    int m_start[NUM_CH];
    bit m_run[NUM_CH];
    int cyc;

    logic [NUM_CH-1:0]       ec, ee;
    logic [NUM_CH*DIV_W-1:0] ea;

    always #5 clk_100m = ~clk_100m;

    clk_div_bank #(
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk_100m   (clk_100m),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .sync_all   (sync_all),
        .clk_out    (clk_out),
        .ce_out     (ce_out),
        .active_div (active_div)
    );

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_a[i] = DEF_DIV;
            m_s[i] = DEF_DIV;
            m_start[i] = 0;
            m_run[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit we, input int ch, input int div, input bit sy);
        cyc++;
        for (int i = 0; i < NUM_CH; i++) begin
            bit wr;
            bit start;
            wr = we && (ch == i);
            start = 1'b0;
            if (sy) begin
                m_a[i] = wr ? div : m_s[i];
                start = 1'b1;
            end else if (!m_run[i] || (cyc - m_start[i] == m_a[i])) begin
                m_a[i] = m_s[i];
                start = 1'b1;
            end
            if (start) begin
                m_start[i] = cyc;
                m_run[i] = (m_a[i] >= 2);
            end
            if (wr) m_s[i] = div;
        end
    endtask

    task automatic model_exp(output logic [NUM_CH-1:0] c, output logic [NUM_CH-1:0] e,
                             output logic [NUM_CH*DIV_W-1:0] a);
        for (int i = 0; i < NUM_CH; i++) begin
            int age;
            age = cyc - m_start[i];
            c[i] = m_run[i] && (age < m_a[i] / 2);
            e[i] = m_run[i] && (age == 0);
            a[i*DIV_W +: DIV_W] = DIV_W'(m_a[i]);
        end
    endtask

    task automatic tick(input bit we, input int ch, input int div, input bit sy);
        cfg_we = we;
        cfg_ch = CH_W'(ch);
        cfg_div = DIV_W'(div);
        sync_all = sy;
        @(posedge clk_100m);
        model_step(we, ch, div, sy);
        #1;
        cfg_we = 1'b0;
        sync_all = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_100m);
        #1;
        checks++;
        if (clk_out !== '0 || ce_out !== '0 || active_div !== {NUM_CH{8'd4}}) begin
            errors++;
            $display("FAIL reset_state clk=%h ce=%h div=%h want 0 0 %h", clk_out, ce_out,
                     active_div, {NUM_CH{8'd4}});
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [NUM_CH-1:0] wc, we_;
            tick(0, 0, 0, 0);
            wc = ((k % 4) < 2) ? '1 : '0;
            we_ = ((k % 4) == 0) ? '1 : '0;
            checks++;
            if (clk_out !== wc || ce_out !== we_) begin
                errors++;
                $display("FAIL reset_pattern k=%0d clk=%h ce=%h want %h %h", k, clk_out,
                         ce_out, wc, we_);
            end
        end
    endtask

    task automatic test_ratio_change();
        int n;
        int highs;
        for (int k = 0; k < 8 && (cyc - m_start[1] != 1); k++) tick(0, 0, 0, 0);
        tick(1, 1, 10, 0);
        n = 0;
        while (ce_out[1] !== 1'b1 && n < 20) begin
            tick(0, 0, 0, 0);
            n++;
            model_exp(ec, ee, ea);
            checks++;
            if ({clk_out, ce_out, active_div} !== {ec, ee, ea}) begin
                errors++;
                $display("FAIL ratio10_model cyc=%0d clk=%h/%h ce=%h/%h div=%h/%h", cyc,
                         clk_out, ec, ce_out, ee, active_div, ea);
            end
        end
        checks++;
        if (n != 2 || active_div[1*DIV_W +: DIV_W] !== 8'd10) begin
            errors++;
            $display("FAIL ratio10_commit ticks=%0d div=%0d want 2 10", n,
                     active_div[1*DIV_W +: DIV_W]);
        end
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick(0, 0, 0, 0);
            if (clk_out[1] === 1'b1) highs++;
        end
        checks++;
        if (highs != 5) begin
            errors++;
            $display("FAIL ratio10_duty highs=%0d want 5", highs);
        end
    endtask

    task automatic test_odd_ratio();
        int n;
        int highs;
        tick(1, 0, 5, 0);
        n = 0;
        do begin
            tick(0, 0, 0, 0);
            n++;
        end while (!(ce_out[0] === 1'b1 && active_div[DIV_W-1:0] === 8'd5) && n < 12);
        highs = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick(0, 0, 0, 0);
            if (clk_out[0] === 1'b1) highs++;
        end
        checks++;
        if (n >= 12 || highs != 2) begin
            errors++;
            $display("FAIL odd5_duty wait=%0d highs=%0d want <12 2", n, highs);
        end
    endtask

    task automatic test_stop_restart();
        tick(1, 2, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick(0, 0, 0, 0);
            model_exp(ec, ee, ea);
            checks++;
            if ({clk_out, ce_out, active_div} !== {ec, ee, ea}) begin
                errors++;
                $display("FAIL stop_model cyc=%0d clk=%h/%h ce=%h/%h div=%h/%h", cyc,
                         clk_out, ec, ce_out, ee, active_div, ea);
            end
        end
        checks++;
        if (clk_out[2] !== 1'b0 || active_div[2*DIV_W +: DIV_W] !== 8'd0) begin
            errors++;
            $display("FAIL stop_state clk=%b div=%0d want 0 0", clk_out[2],
                     active_div[2*DIV_W +: DIV_W]);
        end
        tick(1, 2, 6, 0);
        checks++;
        if (ce_out[2] !== 1'b0) begin
            errors++;
            $display("FAIL restart_early ce=%b want 0", ce_out[2]);
        end
        tick(0, 0, 0, 0);
        checks++;
        if (ce_out[2] !== 1'b1 || clk_out[2] !== 1'b1 ||
            active_div[2*DIV_W +: DIV_W] !== 8'd6) begin
            errors++;
            $display("FAIL restart_phase0 ce=%b clk=%b div=%0d want 1 1 6", ce_out[2],
                     clk_out[2], active_div[2*DIV_W +: DIV_W]);
        end
    endtask

    task automatic test_sync_lcm();
        bit early;
        tick(1, 0, 3, 0);
        tick(1, 1, 4, 0);
        tick(1, 2, 5, 0);
        tick(1, 3, 7, 0);
        repeat ($urandom_range(10, 60)) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        checks++;
        if (ce_out[3:0] !== 4'hf) begin
            errors++;
            $display("FAIL sync_align ce=%h want f", ce_out[3:0]);
        end
        early = 1'b0;
        for (int j = 1; j <= 420; j++) begin
            tick(0, 0, 0, 0);
            if (j < 420 && ce_out[3:0] === 4'hf) early = 1'b1;
        end
        checks++;
        if (early || ce_out[3:0] !== 4'hf) begin
            errors++;
            $display("FAIL sync_lcm early=%b ce=%h want 0 f", early, ce_out[3:0]);
        end
    endtask

    task automatic test_bad_channel();
        tick(1, NUM_CH, 9, 0);
        tick(1, NUM_CH + 1, 2, 0);
        for (int k = 0; k < 12; k++) begin
            tick(0, 0, 0, 0);
            model_exp(ec, ee, ea);
            checks++;
            if ({clk_out, ce_out, active_div} !== {ec, ee, ea}) begin
                errors++;
                $display("FAIL bad_ch cyc=%0d clk=%h/%h ce=%h/%h div=%h/%h", cyc, clk_out,
                         ec, ce_out, ee, active_div, ea);
            end
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int k = 0; k < 1500; k++) begin
            bit we;
            bit sy;
            int ch;
            int div;
            we = ($urandom_range(0, 5) == 0);
            sy = ($urandom_range(0, 79) == 0);
            ch = $urandom_range(0, 7);
            div = $urandom_range(0, 12);
            tick(we, ch, div, sy);
            model_exp(ec, ee, ea);
            checks++;
            if ({clk_out, ce_out, active_div} !== {ec, ee, ea}) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cyc=%0d clk=%h/%h ce=%h/%h div=%h/%h", cyc,
                             clk_out, ec, ce_out, ee, active_div, ea);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 9, 0);
        repeat (5) tick(0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (clk_out !== '0 || ce_out !== '0 || active_div !== {NUM_CH{8'd4}}) begin
            errors++;
            $display("FAIL reset_mid clk=%h ce=%h div=%h want 0 0 %h", clk_out, ce_out,
                     active_div, {NUM_CH{8'd4}});
        end
        @(posedge clk_100m);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            tick(0, 0, 0, 0);
            model_exp(ec, ee, ea);
            checks++;
            if ({clk_out, ce_out, active_div} !== {ec, ee, ea}) begin
                errors++;
                $display("FAIL after_reset cyc=%0d clk=%h/%h ce=%h/%h div=%h/%h", cyc,
                         clk_out, ec, ce_out, ee, active_div, ea);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ratio_change();
        test_odd_ratio();
        test_stop_restart();
        test_sync_lcm();
        test_bad_channel();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock divider driven from `clk_100m`. Each channel divides by its own runtime-programmable integer ratio, producing a registered divided clock and a one-cycle clock-enable strobe. Ratio changes are glitch-free and take effect only at period boundaries. A sync pulse phase-aligns all channels. It replaces fixed-ratio divider instances feeding camera XCLK, SCCB and pixel-pipeline enables.

## Interface
Parameters:
- `NUM_CH`, 4: number of output channels (1..16).
- `DIV_W`, 8: width of each divide ratio.
- `DEF_DIV`, 4: ratio loaded into every channel at reset (must be ≥2).

Ports:
- `clk_100m`  in  1  sole clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `cfg_we`  in  1  one-cycle write strobe for a channel ratio.
- `cfg_ch`  in  $clog2(NUM_CH) (min 1)  target channel.
- `cfg_div`  in  DIV_W  new ratio N.
- `sync_all`  in  1  one-cycle pulse; restarts all channels at phase 0.
- `clk_out`  out  NUM_CH  divided clocks, bit i = channel i.
- `ce_out`  out  NUM_CH  one-cycle strobe at each channel's period start.
- `active_div`  out  NUM_CH*DIV_W  ratio currently in effect per channel.

## Operation
- Per channel: shadow ratio S, active ratio A, phase counter P (0..A-1).
- Reset: S=A=DEF_DIV, P=0, clk_out=0, ce_out=0, active_div={NUM_CH{DEF_DIV}}.
- Running (A≥2): P increments each cycle and wraps A-1→0. Phase 0: ce_out=1, clk_out=1. clk_out=1 while P<floor(A/2), else 0.
- Ratio write: when cfg_we=1, cfg_div is written to S[cfg_ch]. When cfg_ch≥NUM_CH, the write is ignored. A later write before commit overwrites S (last write wins).
- Commit: S→A at the cycle P wraps to 0, so the new period starts with the new ratio. There are no truncated or stretched periods, except for a sync_all restart.
- Stop: if A<2 (0 or 1), the channel is stopped: clk_out=0, ce_out=0, P held at 0. While stopped, S→A commits on the cycle after the write. A channel restarted by a commit begins at phase 0.
- sync_all: all channels commit S→A and enter phase 0 on the next edge. This overrides wrap timing.
- Simultaneous events: cfg_we together with sync_all commits the newly written value. cfg_we to a channel at its wrap cycle does not commit that cycle; it commits at the next wrap.
- Reset asserted mid-period: outputs go to 0 immediately. Programmed ratios are lost.

## Timing
- All outputs are registered and contain no combinational paths from inputs.
- The first edge after reset release is phase 0 (clk_out=1, ce_out=1).
- Write-to-effect latency: at most the remainder of the current period plus 1 cycle.
- sync_all latency: 1 cycle.
- active_div updates on the same edge the commit occurs.
- Period of clk_out is A cycles of clk_100m. Duty is floor(A/2)/A without the macro.

## Configuration
- `CLK_DIV_BANK_ODD_HALF_EN`.
- Defined: each channel adds a negedge-`clk_100m` register. For odd A, clk_out is extended by half a cycle, giving exact 50% duty (high (A/2) cycles, e.g. 2.5 of 5). Even ratios are unchanged. ce_out is unaffected.
- Undefined: a single-edge design. Odd ratios run at floor(A/2) cycles high.

## Structure
- Package `clk_div_pkg`: localparam for maximum channel count, the default ratio, and a function for the channel-index width.
- Sub-module `clk_div_ch`: one channel, holding S/A/P, commit logic and the optional negedge stage. The top instantiates NUM_CH copies in a generate loop, plus cfg decode.

## Test plan
- Reset, DEF_DIV=4: clk_out[i] runs 1,1,0,0 repeating from the first edge. ce_out pulses every 4 cycles. active_div=4 on every channel.
- Write ch1=10 at P=1: the current 4-cycle period completes, then clk_out[1] has a period of 10 (5 high, 5 low). The first ce_out[1] at ratio 10 coincides with active_div[1]=10.
- Ratio 5 without the macro: 2 high, 3 low. With the macro: high duration measured as 25 ns at a 10 ns clock.
- Write ch2=0: ch2 stops at the next wrap with clk_out[2]=0. Write ch2=6: ch2 restarts at phase 0 on the next cycle.
- Set channels to ratios 3, 4, 5, 7, run arbitrarily, then pulse sync_all: all ce_out assert together on the next edge and recur at LCM=420 cycles.
- Write cfg_ch=NUM_CH: no active_div change. Assert rst mid-period: clk_out=0 immediately, and ratios revert to DEF_DIV.
